// File: rtl/mure_block_packer_if.sv
// rtl/mure_block_packer_if.sv - block output bus between the block packer and the trace encoder
interface mure_block_packer_if #(
  parameter int N           = 2,
  parameter int XLEN        = 32,
  parameter int ITYPE_LEN   = 3,
  parameter int CAUSE_LEN   = 5,
  parameter int PRIV_LEN    = 2,
  parameter int IRETIRE_LEN = 7
);
  logic [N-1:0]                  valid_o;
  logic [N-1:0][IRETIRE_LEN-1:0] iretire_o;
  logic [N-1:0]                  ilastsize_o;
  logic [N-1:0][ITYPE_LEN-1:0]   itype_o;
  logic [N-1:0][CAUSE_LEN-1:0]   cause_o;
  logic [N-1:0][XLEN-1:0]        tval_o;
  logic [N-1:0][PRIV_LEN-1:0]    priv_o;
  logic [N-1:0][XLEN-1:0]        iaddr_o;
  logic                          ready_i;

  modport master (
    output valid_o, iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o, iaddr_o,
    input  ready_i
  );

  modport slave (
    input  valid_o, iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o, iaddr_o,
    output ready_i
  );
endinterface

// File: rtl/mure_block_packer.sv
// rtl/mure_block_packer.sv - retirement group walker and block packer; MURE_PRIV_CLOSE_EN closes blocks on priv change
module mure_block_packer #(
  parameter int NRET        = 2,
  parameter int N           = 2,
  parameter int IN_DEPTH    = 8,
  parameter int OUT_DEPTH   = 8,
  parameter int XLEN        = 32,
  parameter int ITYPE_LEN   = 3,
  parameter int CAUSE_LEN   = 5,
  parameter int PRIV_LEN    = 2,
  parameter int IRETIRE_LEN = 7
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NRET-1:0]                valid_i,
  input  logic [NRET-1:0][XLEN-1:0]      pc_i,
  input  logic [NRET-1:0][ITYPE_LEN-1:0] itype_i,
  input  logic [NRET-1:0]                compressed_i,
  input  logic [PRIV_LEN-1:0]            priv_i,
  input  logic [CAUSE_LEN-1:0]           cause_i,
  input  logic [XLEN-1:0]                tval_i,
  mure_block_packer_if.master            blk,
  output logic                           overflow_o
);
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int LPW = (NRET > 1) ? $clog2(NRET) : 1;
  localparam logic [IRETIRE_LEN:0] ACC_MAX = {1'b0, {IRETIRE_LEN{1'b1}}};

  logic [NRET-1:0]                r_gv     [IN_DEPTH];
  logic [NRET-1:0][XLEN-1:0]      r_gpc    [IN_DEPTH];
  logic [NRET-1:0][ITYPE_LEN-1:0] r_git    [IN_DEPTH];
  logic [NRET-1:0]                r_gc     [IN_DEPTH];
  logic [PRIV_LEN-1:0]            r_gpriv  [IN_DEPTH];
  logic [CAUSE_LEN-1:0]           r_gcause [IN_DEPTH];
  logic [XLEN-1:0]                r_gtval  [IN_DEPTH];
  logic [IAW:0]                   r_gwr, r_grd;

  logic [IRETIRE_LEN-1:0] r_bret   [OUT_DEPTH];
  logic                   r_bilast [OUT_DEPTH];
  logic [ITYPE_LEN-1:0]   r_bit    [OUT_DEPTH];
  logic [CAUSE_LEN-1:0]   r_bcause [OUT_DEPTH];
  logic [XLEN-1:0]        r_btval  [OUT_DEPTH];
  logic [PRIV_LEN-1:0]    r_bpriv  [OUT_DEPTH];
  logic [XLEN-1:0]        r_baddr  [OUT_DEPTH];
  logic [OAW-1:0]         r_bwr, r_brd;
  logic [OAW:0]           r_bcnt;

  logic [LPW-1:0]         r_lp;
  logic                   r_open;
  logic [IRETIRE_LEN-1:0] r_acc;
  logic                   r_ilast;
  logic [PRIV_LEN-1:0]    r_priv;
  logic [XLEN-1:0]        r_iaddr;

  logic                   w_gempty, w_gfull, w_gpush, w_gpop, w_bfull, w_walk;
  logic [IAW-1:0]         w_gh;
  logic                   w_lv, w_lc, w_trap, w_pchg, w_split, w_adv;
  logic [XLEN-1:0]        w_lpc;
  logic [ITYPE_LEN-1:0]   w_lit;
  logic [IRETIRE_LEN-1:0] w_base;
  logic [IRETIRE_LEN:0]   w_sum;
  logic [OAW:0]           w_npop;

  logic                   w_bpush, w_b_ilast;
  logic [IRETIRE_LEN-1:0] w_b_ret;
  logic [ITYPE_LEN-1:0]   w_b_it;
  logic [CAUSE_LEN-1:0]   w_b_cause;
  logic [XLEN-1:0]        w_b_tval, w_b_addr;
  logic [PRIV_LEN-1:0]    w_b_priv;

  logic                   w_open_n, w_ilast_n;
  logic [IRETIRE_LEN-1:0] w_acc_n;
  logic [PRIV_LEN-1:0]    w_priv_n;
  logic [XLEN-1:0]        w_addr_n;

  assign w_gh     = r_grd[IAW-1:0];
  assign w_gempty = (r_gwr == r_grd);
  assign w_gfull  = (r_gwr[IAW] != r_grd[IAW]) && (r_gwr[IAW-1:0] == r_grd[IAW-1:0]);
  assign w_gpush  = (|valid_i) && (!w_gfull || w_gpop);
  assign w_bfull  = (r_bcnt == (OAW+1)'(OUT_DEPTH));
  assign w_walk   = !w_gempty && !w_bfull;

  assign w_lv   = r_gv[w_gh][r_lp];
  assign w_lpc  = r_gpc[w_gh][r_lp];
  assign w_lit  = r_git[w_gh][r_lp];
  assign w_lc   = r_gc[w_gh][r_lp];
  assign w_trap = (w_lit == ITYPE_LEN'(1)) || (w_lit == ITYPE_LEN'(2));
  assign w_base = r_open ? r_acc : '0;
  assign w_sum  = {1'b0, w_base} + (w_lc ? (IRETIRE_LEN+1)'(1) : (IRETIRE_LEN+1)'(2));

`ifdef MURE_PRIV_CLOSE_EN
  assign w_pchg = r_open && (r_gpriv[w_gh] != r_priv);
`else
  assign w_pchg = 1'b0;
`endif

  // A split closes the open block with itype 0 and re-walks the same lane from IDLE next cycle
  assign w_split = w_lv && !w_trap && r_open && ((w_sum > ACC_MAX) || w_pchg);

  // Walk one lane of the head group: decide the block push, accumulator update and group pop
  always_comb begin
    w_bpush   = 1'b0;
    w_b_ret   = r_acc;
    w_b_ilast = r_ilast;
    w_b_it    = '0;
    w_b_cause = '0;
    w_b_tval  = '0;
    w_b_priv  = r_priv;
    w_b_addr  = r_iaddr;
    w_adv     = 1'b0;
    w_gpop    = 1'b0;
    w_open_n  = r_open;
    w_acc_n   = r_acc;
    w_ilast_n = r_ilast;
    w_priv_n  = r_priv;
    w_addr_n  = r_iaddr;
    if (w_walk) begin
      if (!w_lv) begin
        w_adv = 1'b1;
      end else if (w_trap) begin
        w_bpush   = 1'b1;
        w_b_it    = w_lit;
        w_b_cause = r_gcause[w_gh];
        w_b_tval  = r_gtval[w_gh];
        if (!r_open) begin
          w_b_ret   = '0;
          w_b_ilast = 1'b0;
          w_b_priv  = r_gpriv[w_gh];
          w_b_addr  = w_lpc;
        end
        w_open_n = 1'b0;
        w_gpop   = 1'b1;
      end else if (w_split) begin
        w_bpush  = 1'b1;
        w_open_n = 1'b0;
      end else begin
        w_adv     = 1'b1;
        w_acc_n   = w_sum[IRETIRE_LEN-1:0];
        w_ilast_n = !w_lc;
        if (!r_open) begin
          w_priv_n = r_gpriv[w_gh];
          w_addr_n = w_lpc;
        end
        if (w_lit != '0) begin
          w_bpush   = 1'b1;
          w_b_ret   = w_acc_n;
          w_b_ilast = w_ilast_n;
          w_b_it    = w_lit;
          w_b_priv  = w_priv_n;
          w_b_addr  = w_addr_n;
          w_open_n  = 1'b0;
        end else begin
          w_open_n = 1'b1;
        end
      end
      if (w_adv && (r_lp == LPW'(NRET - 1))) w_gpop = 1'b1;
    end
  end

  // Group FIFO pointers and the sticky drop flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_gwr      <= '0;
      r_grd      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (w_gpush) r_gwr <= r_gwr + (IAW+1)'(1);
      if (w_gpop)  r_grd <= r_grd + (IAW+1)'(1);
      if ((|valid_i) && !w_gpush) overflow_o <= 1'b1;
    end
  end

  // Group FIFO storage
  always_ff @(posedge clk_i) begin
    if (w_gpush) begin
      r_gv[r_gwr[IAW-1:0]]     <= valid_i;
      r_gpc[r_gwr[IAW-1:0]]    <= pc_i;
      r_git[r_gwr[IAW-1:0]]    <= itype_i;
      r_gc[r_gwr[IAW-1:0]]     <= compressed_i;
      r_gpriv[r_gwr[IAW-1:0]]  <= priv_i;
      r_gcause[r_gwr[IAW-1:0]] <= cause_i;
      r_gtval[r_gwr[IAW-1:0]]  <= tval_i;
    end
  end

  // Lane pointer and open-block accumulator
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lp    <= '0;
      r_open  <= 1'b0;
      r_acc   <= '0;
      r_ilast <= 1'b0;
      r_priv  <= '0;
      r_iaddr <= '0;
    end else begin
      if (w_gpop)     r_lp <= '0;
      else if (w_adv) r_lp <= r_lp + LPW'(1);
      r_open  <= w_open_n;
      r_acc   <= w_acc_n;
      r_ilast <= w_ilast_n;
      r_priv  <= w_priv_n;
      r_iaddr <= w_addr_n;
    end
  end

  // Number of blocks leaving this cycle: every visible slot when the encoder is ready
  always_comb begin
    w_npop = '0;
    if (blk.ready_i) w_npop = (r_bcnt < (OAW+1)'(N)) ? r_bcnt : (OAW+1)'(N);
  end

  // Block FIFO pointers and usage
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bwr  <= '0;
      r_brd  <= '0;
      r_bcnt <= '0;
    end else begin
      if (w_bpush) r_bwr <= r_bwr + OAW'(1);
      r_brd  <= r_brd + w_npop[OAW-1:0];
      r_bcnt <= r_bcnt + (OAW+1)'(w_bpush) - w_npop;
    end
  end

  // Block FIFO storage
  always_ff @(posedge clk_i) begin
    if (w_bpush) begin
      r_bret[r_bwr]   <= w_b_ret;
      r_bilast[r_bwr] <= w_b_ilast;
      r_bit[r_bwr]    <= w_b_it;
      r_bcause[r_bwr] <= w_b_cause;
      r_btval[r_bwr]  <= w_b_tval;
      r_bpriv[r_bwr]  <= w_b_priv;
      r_baddr[r_bwr]  <= w_b_addr;
    end
  end

  // Present the oldest blocks on the output slots; empty slots read as zero
  always_comb begin
    for (int k = 0; k < N; k++) begin
      logic [OAW-1:0] idx;
      logic           v;
      idx                  = r_brd + OAW'(k);
      v                    = ((OAW+1)'(k) < r_bcnt);
      blk.valid_o[k]       = v;
      blk.iretire_o[k]     = v ? r_bret[idx]   : '0;
      blk.ilastsize_o[k]   = v ? r_bilast[idx] : 1'b0;
      blk.itype_o[k]       = v ? r_bit[idx]    : '0;
      blk.cause_o[k]       = v ? r_bcause[idx] : '0;
      blk.tval_o[k]        = v ? r_btval[idx]  : '0;
      blk.priv_o[k]        = v ? r_bpriv[idx]  : '0;
      blk.iaddr_o[k]       = v ? r_baddr[idx]  : '0;
    end
  end
endmodule

// File: tb/tb_mure_block_packer.sv
// tb/tb_mure_block_packer.sv - self-checking bench for mure_block_packer
module tb_mure_block_packer;
  localparam int NRET = 2, N = 2, IN_DEPTH = 8, OUT_DEPTH = 8;
  localparam int XLEN = 32, ITYPE_LEN = 3, CAUSE_LEN = 5, PRIV_LEN = 2, IRL = 3;
  localparam int ACC_MAX = (1 << IRL) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NRET-1:0]                valid_i = '0;
  logic [NRET-1:0][XLEN-1:0]      pc_i = '0;
  logic [NRET-1:0][ITYPE_LEN-1:0] itype_i = '0;
  logic [NRET-1:0]                compressed_i = '0;
  logic [PRIV_LEN-1:0]            priv_i = '0;
  logic [CAUSE_LEN-1:0]           cause_i = '0;
  logic [XLEN-1:0]                tval_i = '0;
  logic                           overflow_o;

  mure_block_packer_if #(.N(N), .XLEN(XLEN), .ITYPE_LEN(ITYPE_LEN), .CAUSE_LEN(CAUSE_LEN),
                         .PRIV_LEN(PRIV_LEN), .IRETIRE_LEN(IRL)) bus ();

  mure_block_packer #(.NRET(NRET), .N(N), .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH), .XLEN(XLEN),
                      .ITYPE_LEN(ITYPE_LEN), .CAUSE_LEN(CAUSE_LEN), .PRIV_LEN(PRIV_LEN),
                      .IRETIRE_LEN(IRL)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .pc_i(pc_i), .itype_i(itype_i),
    .compressed_i(compressed_i), .priv_i(priv_i), .cause_i(cause_i), .tval_i(tval_i),
    .blk(bus), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IRL-1:0]  iret;
    logic            ilast;
    logic [2:0]      itype;
    logic [4:0]      cause;
    logic [31:0]     tval;
    logic [1:0]      priv;
    logic [31:0]     iaddr;
  } blk_t;

  int   checks = 0;
  int   errors = 0;
  blk_t exp_q[$];

  logic        m_open;
  int          m_acc;
  logic        m_ilast;
  logic [1:0]  m_priv;
  logic [31:0] m_iaddr;

  function automatic blk_t mk(input int iret, input logic il, input logic [2:0] ity,
                              input logic [4:0] ca, input logic [31:0] tv,
                              input logic [1:0] pr, input logic [31:0] ad);
    blk_t b;
    b.iret = IRL'(iret); b.ilast = il; b.itype = ity; b.cause = ca;
    b.tval = tv; b.priv = pr; b.iaddr = ad;
    return b;
  endfunction

  function automatic blk_t slot(input int k);
    return mk(int'(bus.iretire_o[k]), bus.ilastsize_o[k], bus.itype_o[k], bus.cause_o[k],
              bus.tval_o[k], bus.priv_o[k], bus.iaddr_o[k]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid_i = '0; bus.ready_i = 1'b0;
    tick();
    rst = 1'b0;
    m_open = 1'b0; m_acc = 0; m_ilast = 1'b0; m_priv = '0; m_iaddr = '0;
    exp_q.delete();
  endtask

  task automatic push_group(input logic [1:0] v, input logic [31:0] p0, input logic [2:0] t0,
                            input logic c0, input logic [31:0] p1, input logic [2:0] t1,
                            input logic c1, input logic [1:0] pr, input logic [4:0] ca,
                            input logic [31:0] tv);
    valid_i = v; pc_i[0] = p0; pc_i[1] = p1; itype_i[0] = t0; itype_i[1] = t1;
    compressed_i[0] = c0; compressed_i[1] = c1; priv_i = pr; cause_i = ca; tval_i = tv;
    tick();
    valid_i = '0;
  endtask

  // Reference: walks lanes in retirement order and emits closed blocks into exp_q
  task automatic model_group(input logic [1:0] v, input logic [1:0][31:0] pc,
                             input logic [1:0][2:0] it, input logic [1:0] c,
                             input logic [1:0] pr, input logic [4:0] ca, input logic [31:0] tv);
    for (int k = 0; k < NRET; k++) begin
      int inc;
      if (!v[k]) continue;
      if (it[k] == 3'd1 || it[k] == 3'd2) begin
        if (m_open) exp_q.push_back(mk(m_acc, m_ilast, it[k], ca, tv, m_priv, m_iaddr));
        else        exp_q.push_back(mk(0, 1'b0, it[k], ca, tv, pr, pc[k]));
        m_open = 1'b0;
        break;
      end
      inc = c[k] ? 1 : 2;
      if (m_open && (m_acc + inc > ACC_MAX)) begin
        exp_q.push_back(mk(m_acc, m_ilast, 3'd0, 5'd0, 32'd0, m_priv, m_iaddr));
        m_open = 1'b0;
      end
`ifdef MURE_PRIV_CLOSE_EN
      if (m_open && (pr != m_priv)) begin
        exp_q.push_back(mk(m_acc, m_ilast, 3'd0, 5'd0, 32'd0, m_priv, m_iaddr));
        m_open = 1'b0;
      end
`endif
      if (!m_open) begin
        m_open = 1'b1; m_acc = 0; m_iaddr = pc[k]; m_priv = pr;
      end
      m_acc   = m_acc + inc;
      m_ilast = !c[k];
      if (it[k] != 3'd0) begin
        exp_q.push_back(mk(m_acc, m_ilast, it[k], 5'd0, 32'd0, m_priv, m_iaddr));
        m_open = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    blk_t z;
    z = mk(0, 1'b0, 3'd0, 5'd0, 32'd0, 2'd0, 32'd0);
    do_reset();
    checks++;
    if (bus.valid_o !== 2'b00 || overflow_o !== 1'b0 || slot(0) !== z || slot(1) !== z) begin
      errors++;
      $display("FAIL reset_state: valid=%b ovf=%b s0=%h s1=%h, want valid=00 ovf=0 zero fields",
               bus.valid_o, overflow_o, slot(0), slot(1));
    end
    push_group(2'b11, 32'h900, 3'd0, 1'b0, 32'h904, 3'd0, 1'b0, 2'd1, 5'd0, 32'd0);
    push_group(2'b01, 32'h908, 3'd4, 1'b0, 32'h0, 3'd0, 1'b0, 2'd1, 5'd0, 32'd0);
    push_group(2'b01, 32'h910, 3'd4, 1'b0, 32'h0, 3'd0, 1'b0, 2'd1, 5'd0, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (bus.valid_o !== 2'b00 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_midblock_flush: valid=%b ovf=%b, want 00 and 0", bus.valid_o, overflow_o);
    end
    push_group(2'b01, 32'h950, 3'd4, 1'b0, 32'h0, 3'd0, 1'b0, 2'd2, 5'd0, 32'd0);
    tick(); tick();
    checks++;
    if (bus.valid_o !== 2'b01 || slot(0) !== mk(2, 1'b1, 3'd4, 5'd0, 32'd0, 2'd2, 32'h950)) begin
      errors++;
      $display("FAIL reset_fresh_block: valid=%b s0=%h, want 01 %h", bus.valid_o, slot(0),
               mk(2, 1'b1, 3'd4, 5'd0, 32'd0, 2'd2, 32'h950));
    end
  endtask

  task automatic test_latency();
    do_reset();
    push_group(2'b01, 32'h200, 3'd4, 1'b0, 32'h0, 3'd0, 1'b0, 2'd3, 5'd0, 32'd0);
    checks++;
    if (bus.valid_o !== 2'b00) begin
      errors++;
      $display("FAIL latency_early: valid=%b one cycle after push, want 00", bus.valid_o);
    end
    tick();
    checks++;
    if (bus.valid_o !== 2'b01 || slot(0) !== mk(2, 1'b1, 3'd4, 5'd0, 32'd0, 2'd3, 32'h200)) begin
      errors++;
      $display("FAIL latency_t2: valid=%b s0=%h, want 01 %h", bus.valid_o, slot(0),
               mk(2, 1'b1, 3'd4, 5'd0, 32'd0, 2'd3, 32'h200));
    end
  endtask

  task automatic test_basic_block();
    do_reset();
    push_group(2'b11, 32'h100, 3'd0, 1'b0, 32'h104, 3'd0, 1'b0, 2'd3, 5'd0, 32'd0);
    push_group(2'b01, 32'h108, 3'd5, 1'b1, 32'h0, 3'd0, 1'b0, 2'd3, 5'd0, 32'd0);
    tick();
    checks++;
    if (bus.valid_o !== 2'b00) begin
      errors++;
      $display("FAIL basic_not_yet: valid=%b before last lane walked, want 00", bus.valid_o);
    end
    tick();
    checks++;
    if (bus.valid_o !== 2'b01 || slot(0) !== mk(5, 1'b0, 3'd5, 5'd0, 32'd0, 2'd3, 32'h100)) begin
      errors++;
      $display("FAIL basic_block: valid=%b s0=%h, want 01 %h", bus.valid_o, slot(0),
               mk(5, 1'b0, 3'd5, 5'd0, 32'd0, 2'd3, 32'h100));
    end
  endtask

  task automatic test_trap();
    do_reset();
    push_group(2'b11, 32'h300, 3'd0, 1'b0, 32'h304, 3'd0, 1'b0, 2'd1, 5'd0, 32'd0);
    push_group(2'b11, 32'h308, 3'd1, 1'b0, 32'h30a, 3'd0, 1'b1, 2'd1, 5'd2, 32'hDEAD);
    push_group(2'b01, 32'h400, 3'd4, 1'b0, 32'h0, 3'd0, 1'b0, 2'd1, 5'd0, 32'd0);
    repeat (8) tick();
    checks++;
    if (bus.valid_o !== 2'b11 || slot(0) !== mk(4, 1'b1, 3'd1, 5'd2, 32'hDEAD, 2'd1, 32'h300)) begin
      errors++;
      $display("FAIL trap_close: valid=%b s0=%h, want 11 %h", bus.valid_o, slot(0),
               mk(4, 1'b1, 3'd1, 5'd2, 32'hDEAD, 2'd1, 32'h300));
    end
    checks++;
    if (slot(1) !== mk(2, 1'b1, 3'd4, 5'd0, 32'd0, 2'd1, 32'h400)) begin
      errors++;
      $display("FAIL trap_discard_rest: s1=%h, want %h", slot(1),
               mk(2, 1'b1, 3'd4, 5'd0, 32'd0, 2'd1, 32'h400));
    end
    bus.ready_i = 1'b1;
    tick();
    bus.ready_i = 1'b0;
    push_group(2'b01, 32'h500, 3'd2, 1'b0, 32'h0, 3'd0, 1'b0, 2'd0, 5'd7, 32'h55);
    repeat (4) tick();
    checks++;
    if (bus.valid_o !== 2'b01 || slot(0) !== mk(0, 1'b0, 3'd2, 5'd7, 32'h55, 2'd0, 32'h500)) begin
      errors++;
      $display("FAIL trap_idle: valid=%b s0=%h, want 01 %h", bus.valid_o, slot(0),
               mk(0, 1'b0, 3'd2, 5'd7, 32'h55, 2'd0, 32'h500));
    end
  endtask

  task automatic test_hold();
    do_reset();
    push_group(2'b01, 32'hA00, 3'd4, 1'b0, 32'h0, 3'd0, 1'b0, 2'd2, 5'd0, 32'd0);
    push_group(2'b01, 32'hA10, 3'd4, 1'b0, 32'h0, 3'd0, 1'b0, 2'd2, 5'd0, 32'd0);
    push_group(2'b01, 32'hA20, 3'd4, 1'b0, 32'h0, 3'd0, 1'b0, 2'd2, 5'd0, 32'd0);
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (bus.valid_o !== 2'b11 || slot(0) !== mk(2, 1'b1, 3'd4, 5'd0, 32'd0, 2'd2, 32'hA00) ||
          slot(1) !== mk(2, 1'b1, 3'd4, 5'd0, 32'd0, 2'd2, 32'hA10)) begin
        errors++;
        $display("FAIL hold_stable cycle %0d: valid=%b s0=%h s1=%h, want 11 iaddr A00/A10",
                 c, bus.valid_o, slot(0), slot(1));
      end
    end
    bus.ready_i = 1'b1;
    tick();
    bus.ready_i = 1'b0;
    checks++;
    if (bus.valid_o !== 2'b01 || slot(0) !== mk(2, 1'b1, 3'd4, 5'd0, 32'd0, 2'd2, 32'hA20)) begin
      errors++;
      $display("FAIL hold_pop_two: valid=%b s0=%h, want 01 iaddr A20", bus.valid_o, slot(0));
    end
    bus.ready_i = 1'b1;
    tick();
    checks++;
    if (bus.valid_o !== 2'b00) begin
      errors++;
      $display("FAIL hold_pop_last: valid=%b, want 00", bus.valid_o);
    end
  endtask

  task automatic test_overflow();
    int          got;
    logic [31:0] last;
    do_reset();
    for (int g = 0; g < 20; g++)
      push_group(2'b11, 32'hB000 + 32'(16 * g), 3'd0, 1'b0, 32'hB004 + 32'(16 * g), 3'd4, 1'b0,
                 2'd0, 5'd0, 32'd0);
    repeat (5) tick();
    checks++;
    if (overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: overflow=%b, want 1", overflow_o);
    end
    bus.ready_i = 1'b1;
    got = 0;
    last = 32'h0;
    for (int c = 0; c < 40; c++) begin
      for (int k = 0; k < N; k++) begin
        if (bus.valid_o[k]) begin
          checks++;
          if (bus.iretire_o[k] !== 3'd4 || bus.iaddr_o[k][3:0] !== 4'h0 ||
              (got == 0 && bus.iaddr_o[k] !== 32'hB000) || (got > 0 && bus.iaddr_o[k] <= last)) begin
            errors++;
            $display("FAIL overflow_order blk %0d: iret=%0d iaddr=%h, want iret 4, ascending group pcs",
                     got, bus.iretire_o[k], bus.iaddr_o[k]);
          end
          last = bus.iaddr_o[k];
          got++;
        end
      end
      tick();
    end
    checks++;
    if (got != 16 || overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL overflow_drain: blocks=%0d ovf=%b, want 16 and sticky 1", got, overflow_o);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    push_group(2'b11, 32'hD00, 3'd0, 1'b0, 32'hD04, 3'd0, 1'b0, 2'd1, 5'd0, 32'd0);
    push_group(2'b11, 32'hD08, 3'd0, 1'b0, 32'hD0C, 3'd0, 1'b0, 2'd1, 5'd0, 32'd0);
    push_group(2'b01, 32'hD10, 3'd4, 1'b0, 32'h0, 3'd0, 1'b0, 2'd1, 5'd0, 32'd0);
    repeat (10) tick();
    checks++;
    if (bus.valid_o !== 2'b11 || slot(0) !== mk(6, 1'b1, 3'd0, 5'd0, 32'd0, 2'd1, 32'hD00) ||
        slot(1) !== mk(4, 1'b1, 3'd4, 5'd0, 32'd0, 2'd1, 32'hD0C)) begin
      errors++;
      $display("FAIL saturate: valid=%b s0=%h s1=%h, want 11 %h %h", bus.valid_o, slot(0), slot(1),
               mk(6, 1'b1, 3'd0, 5'd0, 32'd0, 2'd1, 32'hD00), mk(4, 1'b1, 3'd4, 5'd0, 32'd0, 2'd1, 32'hD0C));
    end
  endtask

  task automatic test_priv();
    do_reset();
    push_group(2'b11, 32'hC00, 3'd0, 1'b0, 32'hC04, 3'd0, 1'b0, 2'd3, 5'd0, 32'd0);
    push_group(2'b01, 32'hC08, 3'd4, 1'b0, 32'h0, 3'd0, 1'b0, 2'd1, 5'd0, 32'd0);
    repeat (8) tick();
`ifdef MURE_PRIV_CLOSE_EN
    checks++;
    if (bus.valid_o !== 2'b11 || slot(0) !== mk(4, 1'b1, 3'd0, 5'd0, 32'd0, 2'd3, 32'hC00) ||
        slot(1) !== mk(2, 1'b1, 3'd4, 5'd0, 32'd0, 2'd1, 32'hC08)) begin
      errors++;
      $display("FAIL priv_split: valid=%b s0=%h s1=%h", bus.valid_o, slot(0), slot(1));
    end
`else
    checks++;
    if (bus.valid_o !== 2'b01 || slot(0) !== mk(6, 1'b1, 3'd4, 5'd0, 32'd0, 2'd3, 32'hC00)) begin
      errors++;
      $display("FAIL priv_ignored: valid=%b s0=%h, want 01 %h", bus.valid_o, slot(0),
               mk(6, 1'b1, 3'd4, 5'd0, 32'd0, 2'd3, 32'hC00));
    end
`endif
  endtask

  task automatic test_random();
    logic [1:0]       gv, gc, gpr;
    logic [1:0][31:0] gpc;
    logic [1:0][2:0]  git;
    logic [4:0]       gca;
    logic [31:0]      gtv;
    int               r;
    do_reset();
    for (int cyc = 0; cyc < 460; cyc++) begin
      bus.ready_i = (cyc >= 400) || ($urandom_range(0, 3) != 0);
      checks++;
      if (bus.valid_o === 2'b10) begin
        errors++;
        $display("FAIL rand_thermometer cycle %0d: valid=%b", cyc, bus.valid_o);
      end
      if (bus.ready_i) begin
        for (int k = 0; k < N; k++) begin
          if (bus.valid_o[k]) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL rand_extra_block cycle %0d slot %0d: got %h, want none", cyc, k, slot(k));
            end else begin
              if (slot(k) !== exp_q[0]) begin
                errors++;
                $display("FAIL rand_block cycle %0d slot %0d: got %h want %h", cyc, k, slot(k), exp_q[0]);
              end
              void'(exp_q.pop_front());
            end
          end
        end
      end
      if (cyc < 400 && (cyc % 4) == 0) begin
        gv = 2'($urandom_range(1, 3));
        for (int k = 0; k < NRET; k++) begin
          gpc[k] = $urandom & 32'hFFFF_FFFE;
          gc[k]  = 1'($urandom_range(0, 1));
          r      = $urandom_range(0, 9);
          git[k] = (r < 6) ? 3'd0 : (r < 8) ? 3'($urandom_range(4, 7)) : (r == 8) ? 3'd1 : 3'd2;
        end
        gpr = 2'($urandom_range(0, 3));
        gca = 5'($urandom_range(0, 31));
        gtv = $urandom;
        if (cyc == 396) begin
          gv = 2'b01; git[0] = 3'd4;
        end
        valid_i = gv; pc_i = gpc; itype_i = git; compressed_i = gc;
        priv_i = gpr; cause_i = gca; tval_i = gtv;
        model_group(gv, gpc, git, gc, gpr, gca, gtv);
      end else begin
        valid_i = '0;
      end
      tick();
    end
    checks++;
    if (exp_q.size() != 0 || bus.valid_o !== 2'b00 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL rand_drain: pending=%0d valid=%b ovf=%b, want 0 00 0", exp_q.size(), bus.valid_o,
               overflow_o);
    end
  endtask

  initial begin
    bus.ready_i = 1'b0;
    test_reset();
    test_latency();
    test_basic_block();
    test_trap();
    test_hold();
    test_saturate();
    test_priv();
    test_overflow();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
